// File: rtl/tester_ctrl_fsm.sv
// Tester control FSM: decodes UART command bytes and push buttons, drives pattern-memory
// writes/reads and UART replies, and issues a timed reset pulse. Optional: TESTER_ECHO_EN.
module tester_ctrl_fsm #(
    parameter  int DATA_W   = 6,
    parameter  int CH_N     = 4,
    parameter  int RST_CYC  = 4,
    parameter  int WAIT_MAX = 255,
    localparam int ADDR_W   = $clog2(CH_N)
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_push_sw,
    input  logic              in_push_rst,
    input  logic              in_urx_vld,
    input  logic [7:0]        in_urx,
    input  logic [DATA_W-1:0] in_mem,
    input  logic              in_mem_w_rd,
    input  logic              in_utx_s_bs,
    input  logic              in_utx_s_rd,
    output logic [DATA_W-1:0] out_mem,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic              out_mem_w_en,
    output logic [7:0]        out_utx_data,
    output logic              out_utx_s_en,
    output logic              out_rst,
    output logic              out_err
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam int RST_W  = $clog2(RST_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_MEM_WR, S_MEM_RD, S_RD_CAP, S_TX_REQ, S_TX_WAIT, S_RST_OUT
    } state_t;

    state_t              state;
    logic [7:0]          cmd;
    logic                sw_q;
    logic                btn_rst_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [RST_W-1:0]    rst_cnt;
`ifdef TESTER_ECHO_EN
    logic                echo_pend;
`endif

    logic sw_edge;
    logic btn_rst_edge;

    assign sw_edge      = in_push_sw  & ~sw_q;
    assign btn_rst_edge = in_push_rst & ~btn_rst_q;

    // Read reply: tag 2'b10 in the top bits, slot data right-aligned, zero padding between.
    function automatic logic [7:0] rd_byte(input logic [DATA_W-1:0] d);
        logic [7:0] b;
        b              = 8'h80;
        b[DATA_W-1:0]  = d;
        return b;
    endfunction

    // NOTE: all state and outputs update with non-blocking assignments so every branch
    // below sees the values from before this clock edge.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state        <= S_IDLE;
            cmd          <= '0;
            sw_q         <= 1'b0;
            btn_rst_q    <= 1'b0;
            wait_cnt     <= '0;
            rst_cnt      <= '0;
            out_mem      <= '0;
            out_mem_addr <= '0;
            out_mem_w_en <= 1'b0;
            out_utx_data <= '0;
            out_utx_s_en <= 1'b0;
            out_rst      <= 1'b0;
            out_err      <= 1'b0;
`ifdef TESTER_ECHO_EN
            echo_pend    <= 1'b0;
`endif
        end else begin
            sw_q         <= in_push_sw;
            btn_rst_q    <= in_push_rst;
            out_utx_s_en <= 1'b0;

            // Only IDLE accepts bytes; anything arriving elsewhere is lost.
            if (in_urx_vld && state != S_IDLE) out_err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (btn_rst_edge) begin
                        out_rst <= 1'b1;
                        rst_cnt <= '0;
                        state   <= S_RST_OUT;
                    end else if (in_urx_vld) begin
                        cmd <= in_urx;
`ifdef TESTER_ECHO_EN
                        out_utx_data <= in_urx;
                        echo_pend    <= 1'b1;
                        wait_cnt     <= '0;
                        state        <= S_TX_REQ;
`else
                        state <= S_DECODE;
`endif
                    end else if (sw_edge) begin
                        state <= S_MEM_RD;
                    end
                end

                S_DECODE: begin
                    case (cmd[7:6])
                        2'b00: begin
                            out_mem      <= cmd[DATA_W-1:0];
                            out_mem_w_en <= 1'b1;
                            wait_cnt     <= '0;
                            state        <= S_MEM_WR;
                        end
                        2'b01: begin
                            if (int'(cmd[5:0]) < CH_N) out_mem_addr <= cmd[ADDR_W-1:0];
                            else                       out_err      <= 1'b1;
                            state <= S_IDLE;
                        end
                        2'b10: state <= S_MEM_RD;
                        default: begin
                            out_mem_addr <= '0;
                            out_rst      <= 1'b1;
                            rst_cnt      <= '0;
                            state        <= S_RST_OUT;
                        end
                    endcase
                end

                S_MEM_WR: begin
                    if (in_mem_w_rd) begin
                        out_mem_w_en <= 1'b0;
                        state        <= S_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        out_mem_w_en <= 1'b0;
                        out_err      <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_MEM_RD: state <= S_RD_CAP;

                S_RD_CAP: begin
                    out_utx_data <= rd_byte(in_mem);
                    wait_cnt     <= '0;
                    state        <= S_TX_REQ;
                end

                S_TX_REQ: begin
                    if (!in_utx_s_bs) begin
                        out_utx_s_en <= 1'b1;
                        wait_cnt     <= '0;
                        state        <= S_TX_WAIT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        out_err <= 1'b1;
                        state   <= S_IDLE;
`ifdef TESTER_ECHO_EN
                        echo_pend <= 1'b0;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_TX_WAIT: begin
                    if (in_utx_s_rd) begin
`ifdef TESTER_ECHO_EN
                        // The echo has gone out; now run the command it announced.
                        if (echo_pend) begin
                            echo_pend <= 1'b0;
                            state     <= S_DECODE;
                        end else begin
                            state <= S_IDLE;
                        end
`else
                        state <= S_IDLE;
`endif
                    end else if (wait_cnt == WAIT_LAST) begin
                        out_err <= 1'b1;
                        state   <= S_IDLE;
`ifdef TESTER_ECHO_EN
                        echo_pend <= 1'b0;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_RST_OUT: begin
                    if (rst_cnt == RST_LAST) begin
                        out_rst <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
